ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, word address width of the shared RAM.
REQ-002 Parameter DATA_WIDTH, default 8, data word width of the shared RAM.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst_l  input  1  reset; asynchronous, active-low.
REQ-005 req_valid  input  [1:0]  per-requester request valid.
REQ-006 req_ready  output  [1:0]  per-requester request accept, one-hot or zero.
REQ-007 req_wr  input  [1:0]  per-requester 1=write, 0=read.
REQ-008 req_addr  input  [ADDR_WIDTH-1:0] x2 (unpacked [0:1])  per-requester word address.
REQ-009 req_wdata  input  [DATA_WIDTH-1:0] x2 (unpacked [0:1])  per-requester write data.
REQ-010 rsp_valid  output  [1:0]  per-requester response valid.
REQ-011 rsp_ready  input  [1:0]  per-requester response accept.
REQ-012 rsp_rdata  output  [DATA_WIDTH-1:0] x2 (unpacked [0:1])  read data; 0 for write responses.
REQ-013 ram_wr  output  1  RAM write strobe.
REQ-014 ram_addr  output  ADDR_WIDTH  RAM address.
REQ-015 ram_wdata  output  DATA_WIDTH  RAM write data.
REQ-016 ram_rdata  input  DATA_WIDTH  RAM combinational read data, valid only while ram_wr=0.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP; one transaction in flight at a time.
REQ-018 IDLE: if any req_valid, the arbiter grants one requester, asserts its req_ready combinationally for that cycle, latches wr/addr/wdata and grant index, then goes to ACCESS.
REQ-019 Arbitration is round-robin: on a tie, the requester not granted last wins; a sole requester always wins.
REQ-020 ACCESS (exactly 1 cycle): ram_addr and ram_wdata carry the latched values; ram_wr=1 only for a latched write; on a read, ram_rdata is registered into the granted rsp_rdata at the end of the cycle; the FSM then goes to RESP.
REQ-021 RESP: rsp_valid of the granted requester is held at 1, and its rsp_rdata is held stable, until rsp_ready is seen high; the FSM then goes to IDLE.
REQ-022 Latency: a request accepted in cycle N gives rsp_valid in cycle N+2; minimum issue interval is 3 cycles.
REQ-023 req_ready=0 in ACCESS and RESP; a new grant can occur only in IDLE.
REQ-024 Outside ACCESS: ram_wr=0, and ram_addr/ram_wdata hold their last values.
REQ-025 The grant pointer updates only on acceptance.
REQ-026 A req_valid deasserted before acceptance is dropped without side effects.
REQ-027 rsp_ready on a non-granted index is ignored.

Reset
REQ-028 rst_l low forces, immediately and regardless of clk: state IDLE; req_ready, rsp_valid, ram_wr = 0; ram_addr, ram_wdata, rsp_rdata = 0; grant pointer = requester 1 (requester 0 wins the first tie).
REQ-029 Reset during ACCESS aborts the write (ram_wr drops at once); no response is issued after release.

Configuration
REQ-030 With RAM_ARBITER_STATS_EN defined, the block adds output ports grant_cnt0 and grant_cnt1, each 16 bits: grants per requester, saturating at 0xFFFF, reset to 0.
REQ-031 Without RAM_ARBITER_STATS_EN, those ports and counters do not exist, and all other behaviour is identical.

Structure
REQ-032 Package ram_arbiter_pkg holds the state enum (IDLE/ACCESS/RESP), NUM_REQ=2 and STATS_WIDTH=16.
REQ-033 Round-robin grant logic lives in sub-module ram_arbiter_rr (inputs: valid[1:0], last grant; outputs: one-hot grant, index).

Verification
REQ-034 Reset, then req0 writes addr 3, data 0x5A -> ram_wr=1 for exactly 1 cycle with addr 3/data 0x5A; rsp_valid[0]=1 two cycles after accept; rsp_rdata[0]=0.
REQ-035 Then req1 reads addr 3 -> rsp_rdata[1]=0x5A in RESP, with ram_wr=0 throughout.
REQ-036 req_valid=2'b11 held continuously, rsp_ready=2'b11 -> grant order 0,1,0,1, one accept every 3 cycles.
REQ-037 rsp_ready[0]=0 for 5 cycles while req1 is valid -> rsp_valid[0] and rsp_rdata[0] held stable, req_ready[1]=0 until rsp_ready[0]=1.
REQ-038 rst_l low during ACCESS of a write -> ram_wr=0 immediately, all outputs 0, no response after release; next tie grants req0.
REQ-039 With RAM_ARBITER_STATS_EN: 3 req0 grants and 1 req1 grant -> grant_cnt0=3, grant_cnt1=1; both read 0 after reset.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared types and constants for the two-port RAM arbiter.
//   state_e      - arbiter FSM states (IDLE, ACCESS, RESP)
//   NUM_REQ      - number of requesters sharing the RAM
//   IDX_WIDTH    - width of a requester index
//   STATS_WIDTH  - width of the optional per-requester grant counters
//   sat_inc()    - saturating increment for the grant counters
package ram_arbiter_pkg;

  localparam int unsigned NUM_REQ     = 2;
  localparam int unsigned IDX_WIDTH   = 1;
  localparam int unsigned STATS_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] v);
    return (&v) ? v : v + STATS_WIDTH'(1);
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: request/response handshakes of both requesters plus the RAM port.
//   req_valid/req_ready/req_wr/req_addr/req_wdata - per-requester request channel
//   rsp_valid/rsp_ready/rsp_rdata                 - per-requester response channel
//   ram_wr/ram_addr/ram_wdata/ram_rdata           - single-port RAM (combinational read)
// Modports: slave = arbiter side, master = requesters + RAM side.
interface ram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  import ram_arbiter_pkg::*;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_wr;
  logic [ADDR_WIDTH-1:0] req_addr  [0:NUM_REQ-1];
  logic [DATA_WIDTH-1:0] req_wdata [0:NUM_REQ-1];

  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata [0:NUM_REQ-1];

  logic                  ram_wr;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, ram_wr, ram_addr, ram_wdata
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, ram_wr, ram_addr, ram_wdata
  );

endinterface

// File: rtl/ram_arbiter_rr.sv
// ram_arbiter_rr: combinational round-robin pick among NUM_REQ requesters.
//   valid - request valid per requester
//   last  - index of the requester granted most recently
//   grant - one-hot grant (zero when nothing is valid)
//   idx   - index of the granted requester (0 when nothing is valid)
// Priority starts at the requester after 'last', so a tie goes to whoever was not
// served last, while a sole requester always wins.
module ram_arbiter_rr
  import ram_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0]   valid,
  input  logic [IDX_WIDTH-1:0] last,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_WIDTH-1:0] idx
);

  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    cand  = 0;
    // Walk from the farthest to the nearest candidate; the nearest valid one
    // overrides any earlier pick.
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = (int'(last) + off) % int'(NUM_REQ);
      if (valid[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = IDX_WIDTH'(cand);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between two requesters, one transaction
// at a time (IDLE -> ACCESS -> RESP), with round-robin arbitration.
//   clk   - clock, all state on posedge
//   rst_l - asynchronous active-low reset
//   bus   - ram_arbiter_if.slave: request/response channels and RAM port
//   grant_cnt0/1 - 16-bit saturating grant counters, present only when the
//                  macro RAM_ARBITER_STATS_EN is defined
// Timing: accept in cycle N (IDLE), RAM access in N+1, rsp_valid from N+2 until the
// granted requester's rsp_ready is seen.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_l,
  ram_arbiter_if.slave           bus
`ifdef RAM_ARBITER_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] grant_cnt0,
  output logic [STATS_WIDTH-1:0] grant_cnt1
`endif
);

  state_e                state_q;
  logic [IDX_WIDTH-1:0]  last_q;
  logic [IDX_WIDTH-1:0]  gnt_idx_q;
  logic                  ram_wr_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q [NUM_REQ];

  logic [NUM_REQ-1:0]    rr_grant;
  logic [IDX_WIDTH-1:0]  rr_idx;
  logic                  accept;

  ram_arbiter_rr u_rr (
    .valid (bus.req_valid),
    .last  (last_q),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  // req_ready is combinational from req_valid, so it must also be gated by rst_l
  // to read zero while reset is held.
  assign accept        = rst_l && (state_q == IDLE) && (|bus.req_valid);
  assign bus.req_ready = accept ? rr_grant : '0;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= IDLE;
      last_q      <= IDX_WIDTH'(NUM_REQ - 1);
      gnt_idx_q   <= '0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rsp_valid_q <= '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        rsp_rdata_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= ACCESS;
            gnt_idx_q   <= rr_idx;
            last_q      <= rr_idx;
            // The RAM-side registers double as the latched request.
            ram_wr_q    <= bus.req_wr[rr_idx];
            ram_addr_q  <= bus.req_addr[rr_idx];
            ram_wdata_q <= bus.req_wdata[rr_idx];
          end
        end
        ACCESS: begin
          state_q                <= RESP;
          ram_wr_q               <= 1'b0;
          rsp_valid_q[gnt_idx_q] <= 1'b1;
          rsp_rdata_q[gnt_idx_q] <= ram_wr_q ? '0 : bus.ram_rdata;
        end
        RESP: begin
          // Only the granted requester's rsp_ready can retire the response.
          if (bus.rsp_ready[gnt_idx_q]) begin
            state_q     <= IDLE;
            rsp_valid_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ram_wr    = ram_wr_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      bus.rsp_rdata[i] = rsp_rdata_q[i];
    end
  end

`ifdef RAM_ARBITER_STATS_EN
  logic [STATS_WIDTH-1:0] grant_cnt_q [NUM_REQ];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        grant_cnt_q[i] <= '0;
      end
    end else if (accept) begin
      grant_cnt_q[rr_idx] <= sat_inc(grant_cnt_q[rr_idx]);
    end
  end

  assign grant_cnt0 = grant_cnt_q[0];
  assign grant_cnt1 = grant_cnt_q[1];
`endif

  // At most one grant per cycle, and the RAM is only written from ACCESS.
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_l)
    $onehot0(bus.req_ready));
  a_wr_in_access: assert property (@(posedge clk) disable iff (!rst_l)
    bus.ram_wr |-> (state_q == ACCESS));
  a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst_l)
    $onehot0(bus.rsp_valid));

endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic clk   = 1'b0;
  logic rst_l = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef RAM_ARBITER_STATS_EN
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;
`endif

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus.slave)
`ifdef RAM_ARBITER_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  // Simple RAM: combinational read, write on posedge while ram_wr is high.
  logic [DW-1:0] mem [16] = '{default: '0};
  assign bus.ram_rdata = mem[bus.ram_addr];
  always @(posedge clk) if (bus.ram_wr) mem[bus.ram_addr] <= bus.ram_wdata;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.req_valid    = 2'b00;
    bus.req_wr       = 2'b00;
    bus.req_addr[0]  = '0;
    bus.req_addr[1]  = '0;
    bus.req_wdata[0] = '0;
    bus.req_wdata[1] = '0;
    bus.rsp_ready    = 2'b11;
  endtask

  // Runs one transaction for requester idx from IDLE; returns in IDLE.
  task automatic do_txn(input int idx, input logic wr, input logic [3:0] a,
                        input logic [7:0] d);
    int n;
    n = 0;
    set_idle();
    bus.req_valid[idx] = 1'b1;
    bus.req_wr[idx]    = wr;
    bus.req_addr[idx]  = a;
    bus.req_wdata[idx] = d;
    #1;
    while (bus.req_ready[idx] !== 1'b1 && n < 8) begin
      step();
      #1;
      n++;
    end
    check("txn_accept", 32'(bus.req_ready[idx]), 32'd1);
    step();
    set_idle();
    step();
    #1;
    check("txn_rsp", 32'(bus.rsp_valid[idx]), 32'd1);
    step();
  endtask

  typedef struct {
    logic [1:0] valid, wr, rsp_ready;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic [1:0] e_req_ready, e_rsp_valid;
    logic       e_ram_wr;
    logic [3:0] e_ram_addr;
    logic [7:0] e_ram_wdata, e_rd0, e_rd1;
  } vec_t;

  vec_t vecs [8];

  // Transaction-level reference model state for the random phase.
  logic [7:0] model_mem [16];
  bit         busy;
  int         age, t_req, last_m, win;
  logic       t_wr;
  logic [7:0] t_rd;
  logic [3:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_rd [2];
  int         m_cnt [2];
  logic [1:0] e_rr, e_rv;
  logic       e_wr;

  int acc_idx [$];
  int acc_cyc [$];

  initial begin
    // inputs, expected outputs
    vecs[0] = '{2'b00, 2'b00, 2'b11, 4'd0, 4'd0, 8'h00, 8'h00,
                2'b00, 2'b00, 1'b0, 4'd0, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{2'b01, 2'b01, 2'b11, 4'd3, 4'd0, 8'h5A, 8'h00,
                2'b01, 2'b00, 1'b0, 4'd0, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{2'b00, 2'b00, 2'b11, 4'd0, 4'd0, 8'h00, 8'h00,
                2'b00, 2'b00, 1'b1, 4'd3, 8'h5A, 8'h00, 8'h00};
    vecs[3] = '{2'b00, 2'b00, 2'b11, 4'd0, 4'd0, 8'h00, 8'h00,
                2'b00, 2'b01, 1'b0, 4'd3, 8'h5A, 8'h00, 8'h00};
    vecs[4] = '{2'b10, 2'b00, 2'b11, 4'd0, 4'd3, 8'h00, 8'h00,
                2'b10, 2'b00, 1'b0, 4'd3, 8'h5A, 8'h00, 8'h00};
    vecs[5] = '{2'b00, 2'b00, 2'b11, 4'd0, 4'd0, 8'h00, 8'h00,
                2'b00, 2'b00, 1'b0, 4'd3, 8'h00, 8'h00, 8'h00};
    vecs[6] = '{2'b00, 2'b00, 2'b11, 4'd0, 4'd0, 8'h00, 8'h00,
                2'b00, 2'b10, 1'b0, 4'd3, 8'h00, 8'h00, 8'h5A};
    vecs[7] = '{2'b00, 2'b00, 2'b11, 4'd0, 4'd0, 8'h00, 8'h00,
                2'b00, 2'b00, 1'b0, 4'd3, 8'h00, 8'h00, 8'h5A};

    // Reset state, with requests pending to show req_ready is held low.
    set_idle();
    bus.req_valid = 2'b11;
    #1 rst_l = 1'b0;
    #2;
    check("rst.req_ready", 32'(bus.req_ready), 32'd0);
    check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst.ram_wr", 32'(bus.ram_wr), 32'd0);
    check("rst.ram_addr", 32'(bus.ram_addr), 32'd0);
    check("rst.ram_wdata", 32'(bus.ram_wdata), 32'd0);
    check("rst.rd0", 32'(bus.rsp_rdata[0]), 32'd0);
    check("rst.rd1", 32'(bus.rsp_rdata[1]), 32'd0);
`ifdef RAM_ARBITER_STATS_EN
    check("rst.cnt0", 32'(grant_cnt0), 32'd0);
    check("rst.cnt1", 32'(grant_cnt1), 32'd0);
`endif
    step();
    step();
    set_idle();
    rst_l = 1'b1;

    // Write then read-back vectors.
    for (int i = 0; i < 8; i++) begin
      step();
      bus.req_valid    = vecs[i].valid;
      bus.req_wr       = vecs[i].wr;
      bus.rsp_ready    = vecs[i].rsp_ready;
      bus.req_addr[0]  = vecs[i].addr0;
      bus.req_addr[1]  = vecs[i].addr1;
      bus.req_wdata[0] = vecs[i].wdata0;
      bus.req_wdata[1] = vecs[i].wdata1;
      #1;
      check($sformatf("v%0d.req_ready", i), 32'(bus.req_ready), 32'(vecs[i].e_req_ready));
      check($sformatf("v%0d.rsp_valid", i), 32'(bus.rsp_valid), 32'(vecs[i].e_rsp_valid));
      check($sformatf("v%0d.ram_wr", i), 32'(bus.ram_wr), 32'(vecs[i].e_ram_wr));
      check($sformatf("v%0d.ram_addr", i), 32'(bus.ram_addr), 32'(vecs[i].e_ram_addr));
      check($sformatf("v%0d.ram_wdata", i), 32'(bus.ram_wdata), 32'(vecs[i].e_ram_wdata));
      check($sformatf("v%0d.rd0", i), 32'(bus.rsp_rdata[0]), 32'(vecs[i].e_rd0));
      check($sformatf("v%0d.rd1", i), 32'(bus.rsp_rdata[1]), 32'(vecs[i].e_rd1));
    end

    // Continuous tie: grants alternate 0,1,0,1, one every 3 cycles.
    step();
    bus.req_valid   = 2'b11;
    bus.req_addr[0] = 4'd1;
    bus.req_addr[1] = 4'd2;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step();
      #1;
      if (bus.req_ready != 2'b00) begin
        acc_idx.push_back(bus.req_ready == 2'b01 ? 0 : 1);
        acc_cyc.push_back(c);
      end
    end
    check("rr.count", 32'(acc_idx.size()), 32'd4);
    for (int k = 0; k < 4 && k < acc_idx.size(); k++) begin
      check($sformatf("rr.idx%0d", k), 32'(acc_idx[k]), 32'(k % 2));
      check($sformatf("rr.cyc%0d", k), 32'(acc_cyc[k]), 32'(3 * k));
    end
    step();
    set_idle();
    step();

    // Response stall: rsp_ready[0] low for 5 cycles while req1 waits.
    bus.req_valid   = 2'b01;
    bus.req_addr[0] = 4'd3;
    bus.rsp_ready   = 2'b10;
    #1;
    check("stall.accept", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 2'b10;
    for (int k = 0; k < 5; k++) begin
      step();
      #1;
      check($sformatf("stall.rv%0d", k), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("stall.rd%0d", k), 32'(bus.rsp_rdata[0]), 32'h5A);
      check($sformatf("stall.rr%0d", k), 32'(bus.req_ready), 32'd0);
    end
    step();
    bus.rsp_ready = 2'b11;
    #1;
    check("stall.rv_rel", 32'(bus.rsp_valid), 32'd1);
    check("stall.rr_rel", 32'(bus.req_ready), 32'd0);
    step();
    #1;
    check("stall.req1", 32'(bus.req_ready), 32'd2);
    step();
    set_idle();
    step();
    step();

    // Reset during a write ACCESS.
    bus.req_valid    = 2'b01;
    bus.req_wr       = 2'b01;
    bus.req_addr[0]  = 4'd5;
    bus.req_wdata[0] = 8'hA5;
    #1;
    check("abort.accept", 32'(bus.req_ready), 32'd1);
    step();
    set_idle();
    #1;
    check("abort.wr_hi", 32'(bus.ram_wr), 32'd1);
    rst_l = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    check("abort.ram_wr", 32'(bus.ram_wr), 32'd0);
    check("abort.ram_addr", 32'(bus.ram_addr), 32'd0);
    check("abort.ram_wdata", 32'(bus.ram_wdata), 32'd0);
    check("abort.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort.req_ready", 32'(bus.req_ready), 32'd0);
    check("abort.rd0", 32'(bus.rsp_rdata[0]), 32'd0);
    check("abort.rd1", 32'(bus.rsp_rdata[1]), 32'd0);
`ifdef RAM_ARBITER_STATS_EN
    check("abort.cnt0", 32'(grant_cnt0), 32'd0);
    check("abort.cnt1", 32'(grant_cnt1), 32'd0);
`endif
    step();
    step();
    set_idle();
    rst_l = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      #1;
      check($sformatf("abort.norsp%0d", k), 32'(bus.rsp_valid), 32'd0);
      check($sformatf("abort.nowr%0d", k), 32'(bus.ram_wr), 32'd0);
    end
    check("abort.mem5", 32'(mem[5]), 32'd0);
    step();
    bus.req_valid = 2'b11;
    #1;
    check("abort.tie", 32'(bus.req_ready), 32'd1);
    step();
    set_idle();
    step();
    step();

    // Grant totals since the last reset: one req0 above, then two more and one req1.
    do_txn(0, 1'b1, 4'd7, 8'h11);
    do_txn(0, 1'b0, 4'd7, 8'h00);
    do_txn(1, 1'b0, 4'd3, 8'h00);
`ifdef RAM_ARBITER_STATS_EN
    check("stats.cnt0", 32'(grant_cnt0), 32'd3);
    check("stats.cnt1", 32'(grant_cnt1), 32'd1);
`endif

    // Randomized traffic against the transaction-level model.
    rst_l = 1'b0;
    set_idle();
    step();
    rst_l = 1'b1;
    for (int i = 0; i < 16; i++) model_mem[i] = mem[i];
    busy    = 1'b0;
    age     = 0;
    t_req   = 0;
    t_wr    = 1'b0;
    t_rd    = '0;
    last_m  = 1;
    m_addr  = '0;
    m_wdata = '0;
    m_rd[0] = '0;
    m_rd[1] = '0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      bus.req_valid    = 2'($urandom_range(0, 3));
      bus.req_wr       = 2'($urandom_range(0, 3));
      bus.req_addr[0]  = 4'($urandom_range(0, 15));
      bus.req_addr[1]  = 4'($urandom_range(0, 15));
      bus.req_wdata[0] = 8'($urandom);
      bus.req_wdata[1] = 8'($urandom);
      bus.rsp_ready    = 2'($urandom_range(0, 3));
      #1;
      e_rr = 2'b00;
      e_rv = 2'b00;
      e_wr = 1'b0;
      win  = 0;
      if (!busy) begin
        if (bus.req_valid != 2'b00) begin
          win = (bus.req_valid == 2'b11) ? 1 - last_m : (bus.req_valid[0] ? 0 : 1);
          e_rr[win] = 1'b1;
        end
      end else if (age == 1) begin
        e_wr = t_wr;
      end else begin
        e_rv[t_req] = 1'b1;
      end
      check("rnd.req_ready", 32'(bus.req_ready), 32'(e_rr));
      check("rnd.rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
      check("rnd.ram_wr", 32'(bus.ram_wr), 32'(e_wr));
      check("rnd.ram_addr", 32'(bus.ram_addr), 32'(m_addr));
      check("rnd.ram_wdata", 32'(bus.ram_wdata), 32'(m_wdata));
      check("rnd.rd0", 32'(bus.rsp_rdata[0]), 32'(m_rd[0]));
      check("rnd.rd1", 32'(bus.rsp_rdata[1]), 32'(m_rd[1]));
`ifdef RAM_ARBITER_STATS_EN
      check("rnd.cnt0", 32'(grant_cnt0), 32'(m_cnt[0]));
      check("rnd.cnt1", 32'(grant_cnt1), 32'(m_cnt[1]));
`endif
      if (!busy) begin
        if (bus.req_valid != 2'b00) begin
          busy    = 1'b1;
          age     = 0;
          t_req   = win;
          last_m  = win;
          t_wr    = bus.req_wr[win];
          m_addr  = bus.req_addr[win];
          m_wdata = bus.req_wdata[win];
          t_rd    = t_wr ? 8'h00 : model_mem[m_addr];
          if (t_wr) model_mem[m_addr] = m_wdata;
          m_cnt[win]++;
        end
      end else begin
        if (age == 1) m_rd[t_req] = t_rd;
        else if (bus.rsp_ready[t_req]) busy = 1'b0;
      end
      if (busy) age++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
